// File: rtl/viterbi_pkg.sv
// viterbi_pkg: code constants and types shared by the convolutional encoder and the Viterbi decoder.
package viterbi_pkg;
  localparam int K = 3;
  localparam int STATE_W = K - 1;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  typedef logic [1:0] sym_t;
  typedef enum logic {S_DATA, S_TAIL} enc_fsm_t;
endpackage

// File: rtl/conv_enc_parity.sv
// conv_enc_parity: maps a {u, state} register image to its code symbol {G0 parity, G1 parity}.
module conv_enc_parity #(
  parameter int K = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic [K-1:0] i_r,
  output logic [1:0]   o_sym
);
  assign o_sym = {^(i_r & G0), ^(i_r & G1)};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 feed-forward convolutional encoder, one registered symbol per info bit.
// Define CONV_ENC_TAIL_EN for zero-tail termination (K-1 tail symbols after each frame).
module conv_encoder #(
  parameter int K = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [1:0] o_sym,
  output logic       o_valid,
  output logic       o_last,
  input  logic       i_ready
);
  import viterbi_pkg::*;
  logic [K-2:0] r_state;
  logic         r_valid;
  logic         r_last;
  sym_t         r_sym;
  sym_t         w_sym;
  logic [K-1:0] w_r;
  logic         w_adv;
  logic         w_load;
  logic         w_u;
  assign w_adv = !r_valid || i_ready;
`ifdef CONV_ENC_TAIL_EN
  localparam int TCNT_W = $clog2(K);
  enc_fsm_t          r_fsm;
  logic [TCNT_W-1:0] r_tcnt;
  logic              w_tail;
  logic              w_tdone;
  assign w_tail  = r_fsm == S_TAIL;
  assign w_tdone = r_tcnt == TCNT_W'(K - 2);
  assign o_ready = !w_tail && w_adv;
  assign w_load  = w_tail ? w_adv : i_valid && o_ready;
  assign w_u     = !w_tail && i_data;
`else
  assign o_ready = w_adv;
  assign w_load  = i_valid && w_adv;
  assign w_u     = i_data;
`endif
  assign w_r = {w_u, r_state};
  conv_enc_parity #(.K(K), .G0(G0), .G1(G1)) u_parity (.i_r(w_r), .o_sym(w_sym));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_sym   <= '0;
      r_last  <= 1'b0;
      r_state <= '0;
`ifdef CONV_ENC_TAIL_EN
      r_fsm   <= S_DATA;
      r_tcnt  <= '0;
`endif
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_sym   <= w_sym;
      r_state <= w_r[K-1:1];
`ifdef CONV_ENC_TAIL_EN
      // tail bits are zeros, so after K-1 of them the state is back at 0
      r_last  <= w_tail && w_tdone;
      r_tcnt  <= w_tail && !w_tdone ? r_tcnt + TCNT_W'(1) : '0;
      r_fsm   <= w_tail ? (w_tdone ? S_DATA : S_TAIL) : (i_last ? S_TAIL : S_DATA);
`else
      r_last  <= i_last;
      if (i_last) r_state <= '0;
`endif
    end else if (i_ready) r_valid <= 1'b0;
  assign o_valid = r_valid;
  assign o_sym   = r_sym;
  assign o_last  = r_last;
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: scoreboard bench with hand-computed symbol streams, both tail configurations.
module tb_conv_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_data, i_valid, i_last, i_ready;
  logic       o_ready, o_valid, o_last;
  logic [1:0] o_sym;
  int         errors = 0;
  int         checks = 0;
  int         rmode = 0;
  int         rc = 0;
  logic [2:0] q[$];
  conv_encoder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_sym(o_sym), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] s, input logic l);
    q.push_back({l, s});
  endtask
  task automatic send(input logic d, input logic l, output int w);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    w = 0;
    while (!o_ready && w < 200) begin
      @(posedge clk); #3;
      w++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: o_ready stuck at 0 for %0d cycles, required 1", w);
    end
    @(posedge clk); #3;
    i_valid = 1'b0;
    i_data  = 1'($urandom);
    i_last  = 1'($urandom);
  endtask
  // Frame A: bits 1,0,1,1
  task automatic exp_a();
    push(2'b11, 0); push(2'b10, 0); push(2'b00, 0);
`ifdef CONV_ENC_TAIL_EN
    push(2'b01, 0); push(2'b01, 0); push(2'b11, 1);
`else
    push(2'b01, 1);
`endif
  endtask
  // Frame B: single bit 1
  task automatic exp_b();
`ifdef CONV_ENC_TAIL_EN
    push(2'b11, 0); push(2'b10, 0); push(2'b11, 1);
`else
    push(2'b11, 1);
`endif
  endtask
  // Frame C: bits 0,1,1,0,1
  task automatic exp_c();
    push(2'b00, 0); push(2'b11, 0); push(2'b01, 0); push(2'b01, 0);
`ifdef CONV_ENC_TAIL_EN
    push(2'b00, 0); push(2'b10, 0); push(2'b11, 1);
`else
    push(2'b00, 1);
`endif
  endtask
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      i_ready = rmode != 0 ? (rc % 4 == 0 || rc % 4 == 3) : 1'b1;
    end
  end
  initial begin
    logic       stall = 1'b0;
    logic [2:0] prev = '0;
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) chk("stall_hold", {5'd0, o_last, o_sym}, {5'd0, prev});
        if (o_valid && i_ready) begin
          if (q.size() == 0) chk("unexpected_symbol", {5'd0, o_last, o_sym}, 8'hff);
          else begin
            e = q.pop_front();
            chk("symbol", {5'd0, o_last, o_sym}, {5'd0, e});
          end
        end
        stall = o_valid && !i_ready;
        prev = {o_last, o_sym};
      end
    end
  end
  initial begin
    int w;
    int n;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_data = 1'b1;
    i_last = 1'b1;
    #2;
    chk("reset_valid", {7'd0, o_valid}, 8'd0);
    chk("reset_sym", {6'd0, o_sym}, 8'd0);
    chk("reset_last", {7'd0, o_last}, 8'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {7'd0, o_ready}, 8'd1);
    @(posedge clk); #3;
    exp_a();
    send(1, 0, w); send(0, 0, w); send(1, 0, w); send(1, 1, w);
    exp_b();
    send(1, 1, w);
`ifdef CONV_ENC_TAIL_EN
    chk("tail_ready_low_cycles", 8'(w), 8'd2);
`else
    chk("back_to_back_wait", 8'(w), 8'd0);
`endif
    rmode = 1;
    exp_c();
    send(0, 0, w); send(1, 0, w); send(1, 0, w); send(0, 0, w); send(1, 1, w);
    exp_c();
    send(0, 0, w); send(1, 0, w); send(1, 0, w); send(0, 0, w); send(1, 1, w);
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    chk("drain_stalled", 8'(q.size()), 8'd0);
    rmode = 0;
    repeat (3) @(posedge clk);
    #3;
    // i_last without i_valid must not produce anything
    i_valid = 1'b0;
    i_last = 1'b1;
    i_data = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("idle_no_valid", {7'd0, o_valid}, 8'd0);
    exp_b();
    send(1, 1, w);
    exp_a();
    send(1, 0, w); send(0, 0, w); send(1, 0, w); send(1, 1, w);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {7'd0, o_valid}, 8'd0);
    chk("async_reset_last", {7'd0, o_last}, 8'd0);
    chk("async_reset_sym", {6'd0, o_sym}, 8'd0);
    q.delete();
    #5;
    rst_n = 1'b1;
    @(posedge clk); #3;
    chk("ready_after_midreset", {7'd0, o_ready}, 8'd1);
    exp_b();
    send(1, 1, w);
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    chk("drain_final", 8'(q.size()), 8'd0);
    @(posedge clk); #3;
    chk("final_idle", {7'd0, o_valid}, 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
